// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the CPU/SPI RAM port arbiter.
package mem_arb_pkg;

  localparam int unsigned DEF_ADDR_BITS = 16;
  localparam int unsigned DEF_DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arb_state_t;

  typedef enum logic {
    GNT_CPU = 1'b0,
    GNT_SPI = 1'b1
  } arb_grant_t;

endpackage

// File: rtl/mem_arb_req_latch.sv
// Single-entry request holder: pending flag, payload capture, dropped-request flag.
module mem_arb_req_latch
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_BITS     = DEF_ADDR_BITS,
  parameter int unsigned DATA_BITS     = DEF_DATA_BITS,
  parameter bit          TRACK_OVERRUN = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_req,
  input  logic                 i_we,
  input  logic [ADDR_BITS-1:0] i_addr,
  input  logic [DATA_BITS-1:0] i_wdata,
  input  logic                 i_clr,
  output logic                 o_pending,
  output logic                 o_we,
  output logic [ADDR_BITS-1:0] o_addr,
  output logic [DATA_BITS-1:0] o_wdata,
  output logic                 o_overrun
);

  logic                 r_pending;
  logic                 r_we;
  logic [ADDR_BITS-1:0] r_addr;
  logic [DATA_BITS-1:0] r_wdata;
  logic                 r_overrun;
  logic                 w_accept;
  logic                 w_drop;

  // A request landing on the clearing edge replaces the finished one.
  assign w_accept = i_req & (~r_pending | i_clr);
  assign w_drop   = i_req & r_pending & ~i_clr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pending <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_accept) begin
        r_pending <= 1'b1;
        r_we      <= i_we;
        r_addr    <= i_addr;
        r_wdata   <= i_wdata;
      end else if (i_clr) begin
        r_pending <= 1'b0;
      end
      if (TRACK_OVERRUN && w_drop) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign o_pending = r_pending;
  assign o_we      = r_we;
  assign o_addr    = r_addr;
  assign o_wdata   = r_wdata;
  assign o_overrun = r_overrun;

endmodule

// File: rtl/mem_port_arbiter.sv
// Per-access round-robin arbiter sharing RAM port A between the Z80 and the SPI loader.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_BITS = DEF_ADDR_BITS,
  parameter int unsigned DATA_BITS = DEF_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 cpu_req,
  input  logic                 cpu_we,
  input  logic [ADDR_BITS-1:0] cpu_addr,
  input  logic [DATA_BITS-1:0] cpu_wdata,
  output logic [DATA_BITS-1:0] cpu_rdata,
  output logic                 cpu_ack,
  output logic                 cpu_wait_n,
  input  logic                 spi_req,
  input  logic                 spi_we,
  input  logic [ADDR_BITS-1:0] spi_addr,
  input  logic [DATA_BITS-1:0] spi_wdata,
  output logic [DATA_BITS-1:0] spi_rdata,
  output logic                 spi_ack,
  input  logic                 spi_only,
  output logic                 spi_overrun,
  output logic                 ram_we,
  output logic [ADDR_BITS-1:0] ram_addr,
  output logic [DATA_BITS-1:0] ram_din,
  input  logic [DATA_BITS-1:0] ram_dout
);

  arb_state_t           r_state,      w_state_nxt;
  arb_grant_t           r_grant,      w_grant_nxt;
  arb_grant_t           r_last_grant, w_last_nxt;
  arb_grant_t           w_win;
  logic                 r_ram_we,     w_ram_we_nxt;
  logic [ADDR_BITS-1:0] r_ram_addr,   w_ram_addr_nxt;
  logic [DATA_BITS-1:0] r_ram_din,    w_ram_din_nxt;
  logic                 r_cpu_ack,    w_cpu_ack_nxt;
  logic                 r_spi_ack,    w_spi_ack_nxt;
  logic [DATA_BITS-1:0] r_cpu_rdata,  w_cpu_rdata_nxt;
  logic [DATA_BITS-1:0] r_spi_rdata,  w_spi_rdata_nxt;
  logic                 w_cpu_clr,    w_spi_clr;
  logic                 w_cpu_pending, w_cpu_we, w_cpu_overrun;
  logic                 w_spi_pending, w_spi_we, w_spi_overrun;
  logic [ADDR_BITS-1:0] w_cpu_addr,   w_spi_addr;
  logic [DATA_BITS-1:0] w_cpu_wdata,  w_spi_wdata;
  logic                 w_cpu_elig,   w_spi_elig;

  mem_arb_req_latch #(
    .ADDR_BITS(ADDR_BITS), .DATA_BITS(DATA_BITS), .TRACK_OVERRUN(1'b0)
  ) u_cpu_latch (
    .clk(clk), .reset_n(reset_n),
    .i_req(cpu_req), .i_we(cpu_we), .i_addr(cpu_addr), .i_wdata(cpu_wdata),
    .i_clr(w_cpu_clr),
    .o_pending(w_cpu_pending), .o_we(w_cpu_we), .o_addr(w_cpu_addr),
    .o_wdata(w_cpu_wdata), .o_overrun(w_cpu_overrun)
  );

  mem_arb_req_latch #(
    .ADDR_BITS(ADDR_BITS), .DATA_BITS(DATA_BITS), .TRACK_OVERRUN(1'b1)
  ) u_spi_latch (
    .clk(clk), .reset_n(reset_n),
    .i_req(spi_req), .i_we(spi_we), .i_addr(spi_addr), .i_wdata(spi_wdata),
    .i_clr(w_spi_clr),
    .o_pending(w_spi_pending), .o_we(w_spi_we), .o_addr(w_spi_addr),
    .o_wdata(w_spi_wdata), .o_overrun(w_spi_overrun)
  );

  assign w_cpu_elig = w_cpu_pending & ~spi_only;
  assign w_spi_elig = w_spi_pending;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_grant      <= GNT_CPU;
      r_last_grant <= GNT_CPU;
      r_ram_we     <= 1'b0;
      r_ram_addr   <= '0;
      r_ram_din    <= '0;
      r_cpu_ack    <= 1'b0;
      r_spi_ack    <= 1'b0;
      r_cpu_rdata  <= '0;
      r_spi_rdata  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_grant      <= w_grant_nxt;
      r_last_grant <= w_last_nxt;
      r_ram_we     <= w_ram_we_nxt;
      r_ram_addr   <= w_ram_addr_nxt;
      r_ram_din    <= w_ram_din_nxt;
      r_cpu_ack    <= w_cpu_ack_nxt;
      r_spi_ack    <= w_spi_ack_nxt;
      r_cpu_rdata  <= w_cpu_rdata_nxt;
      r_spi_rdata  <= w_spi_rdata_nxt;
    end
  end

  // Grant in IDLE, drive the port for ACCESS, collect read data and ack in DONE.
  always_comb begin
    w_state_nxt     = r_state;
    w_grant_nxt     = r_grant;
    w_last_nxt      = r_last_grant;
    w_win           = GNT_CPU;
    w_ram_we_nxt    = 1'b0;
    w_ram_addr_nxt  = r_ram_addr;
    w_ram_din_nxt   = r_ram_din;
    w_cpu_ack_nxt   = 1'b0;
    w_spi_ack_nxt   = 1'b0;
    w_cpu_rdata_nxt = r_cpu_rdata;
    w_spi_rdata_nxt = r_spi_rdata;
    w_cpu_clr       = 1'b0;
    w_spi_clr       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_cpu_elig || w_spi_elig) begin
          if (w_cpu_elig && w_spi_elig) begin
            w_win = (r_last_grant == GNT_CPU) ? GNT_SPI : GNT_CPU;
          end else begin
            w_win = w_spi_elig ? GNT_SPI : GNT_CPU;
          end
          w_grant_nxt = w_win;
          w_last_nxt  = w_win;
          if (w_win == GNT_SPI) begin
            w_ram_we_nxt   = w_spi_we;
            w_ram_addr_nxt = w_spi_addr;
            w_ram_din_nxt  = w_spi_wdata;
          end else begin
            w_ram_we_nxt   = w_cpu_we;
            w_ram_addr_nxt = w_cpu_addr;
            w_ram_din_nxt  = w_cpu_wdata;
          end
          w_state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        w_state_nxt = DONE;
      end
      DONE: begin
        if (r_grant == GNT_SPI) begin
          w_spi_clr       = 1'b1;
          w_spi_rdata_nxt = ram_dout;
          w_spi_ack_nxt   = 1'b1;
        end else begin
          w_cpu_clr       = 1'b1;
          w_cpu_rdata_nxt = ram_dout;
          w_cpu_ack_nxt   = 1'b1;
        end
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign cpu_wait_n  = ~(cpu_req | w_cpu_pending);
  assign cpu_rdata   = r_cpu_rdata;
  assign cpu_ack     = r_cpu_ack;
  assign spi_rdata   = r_spi_rdata;
  assign spi_ack     = r_spi_ack;
  // The CPU latch is built without drop tracking, so its flag is constant 0.
  assign spi_overrun = w_spi_overrun | w_cpu_overrun;
  assign ram_we      = r_ram_we;
  assign ram_addr    = r_ram_addr;
  assign ram_din     = r_ram_din;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed vector table plus hand-written corner sequences for mem_port_arbiter.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic [7:0]  cpu_wdata = '0;
  logic [7:0]  cpu_rdata;
  logic        cpu_ack, cpu_wait_n;
  logic        spi_req = 1'b0, spi_we = 1'b0;
  logic [15:0] spi_addr = '0;
  logic [7:0]  spi_wdata = '0;
  logic [7:0]  spi_rdata;
  logic        spi_ack;
  logic        spi_only = 1'b0;
  logic        spi_overrun;
  logic        ram_we;
  logic [15:0] ram_addr;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout = '0;

  int n_cmp = 0;
  int n_fail = 0;

  mem_port_arbiter #(.ADDR_BITS(16), .DATA_BITS(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_wait_n(cpu_wait_n),
    .spi_req(spi_req), .spi_we(spi_we), .spi_addr(spi_addr), .spi_wdata(spi_wdata),
    .spi_rdata(spi_rdata), .spi_ack(spi_ack), .spi_only(spi_only),
    .spi_overrun(spi_overrun), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  // RAM model: read-first, one-cycle synchronous read, preloaded with a pattern.
  logic [7:0] mem [0:65535];
  bit mem_ready = 1'b0;

  function automatic logic [7:0] pat(int i);
    return 8'(i) ^ 8'(i >> 8) ^ 8'h3C;
  endfunction

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 65536; i++) mem[i] <= pat(i);
      mem_ready <= 1'b1;
      ram_dout  <= '0;
    end else begin
      if (ram_we) mem[ram_addr] <= ram_din;
      ram_dout <= mem[ram_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic        rst;
    logic [1:0]  c;      // {cpu_req, cpu_we}
    logic [15:0] ca;
    logic [7:0]  cd;
    logic [1:0]  s;      // {spi_req, spi_we}
    logic [15:0] sa;
    logic [7:0]  sd;
    logic        so;
    logic        ewe;
    logic [15:0] ea;
    logic [7:0]  ed;
    logic [3:0]  fl;     // {cpu_ack, spi_ack, cpu_wait_n, spi_overrun}
    logic [8:0]  erd;    // {check, rdata} for the acking requester
  } vec_t;

  function automatic vec_t mk(logic rst, logic [1:0] c, logic [15:0] ca, logic [7:0] cd,
                              logic [1:0] s, logic [15:0] sa, logic [7:0] sd, logic so,
                              logic ewe, logic [15:0] ea, logic [7:0] ed, logic [3:0] fl,
                              logic [8:0] erd);
    vec_t v;
    v.rst = rst; v.c = c; v.ca = ca; v.cd = cd; v.s = s; v.sa = sa; v.sd = sd; v.so = so;
    v.ewe = ewe; v.ea = ea; v.ed = ed; v.fl = fl; v.erd = erd;
    return v;
  endfunction

  function automatic vec_t idle(logic ewe, logic [15:0] ea, logic [7:0] ed,
                                logic [3:0] fl, logic [8:0] erd);
    return mk(1'b0, 2'b00, 16'h0, 8'h0, 2'b00, 16'h0, 8'h0, 1'b0, ewe, ea, ed, fl, erd);
  endfunction

  vec_t vecs[$];

  initial begin
    int bad, cack, acks, wes, hits;
    bit got;

    // Reset, SPI write 0x1234<-A5, then CPU read of 0x1234.
    vecs.push_back(mk(1, 2'b00, 16'h0, 8'h0, 2'b00, 16'h0, 8'h0, 0, 0, 16'h0, 8'h0, 4'b0010, 9'h0));
    vecs.push_back(mk(0, 2'b00, 16'h0, 8'h0, 2'b11, 16'h1234, 8'hA5, 0, 0, 16'h0, 8'h0, 4'b0010, 9'h0));
    vecs.push_back(idle(0, 16'h0000, 8'h00, 4'b0010, 9'h0));
    vecs.push_back(idle(1, 16'h1234, 8'hA5, 4'b0010, 9'h0));
    vecs.push_back(idle(0, 16'h1234, 8'hA5, 4'b0010, 9'h0));
    vecs.push_back(idle(0, 16'h1234, 8'hA5, 4'b0110, 9'h0));
    vecs.push_back(mk(0, 2'b10, 16'h1234, 8'h0, 2'b00, 16'h0, 8'h0, 0, 0, 16'h1234, 8'hA5, 4'b0000, 9'h0));
    vecs.push_back(idle(0, 16'h1234, 8'hA5, 4'b0000, 9'h0));
    vecs.push_back(idle(0, 16'h1234, 8'h00, 4'b0000, 9'h0));
    vecs.push_back(idle(0, 16'h1234, 8'h00, 4'b0000, 9'h0));
    vecs.push_back(idle(0, 16'h1234, 8'h00, 4'b1010, 9'h1A5));
    // Reset, then simultaneous CPU read 0x0010 / SPI write 0x0020<-5A: SPI first.
    vecs.push_back(mk(1, 2'b00, 16'h0, 8'h0, 2'b00, 16'h0, 8'h0, 0, 0, 16'h0, 8'h0, 4'b0010, 9'h0));
    vecs.push_back(mk(0, 2'b10, 16'h0010, 8'h0, 2'b11, 16'h0020, 8'h5A, 0, 0, 16'h0, 8'h0, 4'b0000, 9'h0));
    vecs.push_back(idle(0, 16'h0000, 8'h00, 4'b0000, 9'h0));
    vecs.push_back(idle(1, 16'h0020, 8'h5A, 4'b0000, 9'h0));
    vecs.push_back(idle(0, 16'h0020, 8'h5A, 4'b0000, 9'h0));
    vecs.push_back(idle(0, 16'h0020, 8'h5A, 4'b0100, 9'h0));
    vecs.push_back(idle(0, 16'h0010, 8'h00, 4'b0000, 9'h0));
    vecs.push_back(idle(0, 16'h0010, 8'h00, 4'b0000, 9'h0));
    vecs.push_back(idle(0, 16'h0010, 8'h00, 4'b1010, 9'h12C));
    // Lone SPI read of 0x00FF leaves last grant on SPI.
    vecs.push_back(mk(0, 2'b00, 16'h0, 8'h0, 2'b10, 16'h00FF, 8'h0, 0, 0, 16'h0010, 8'h0, 4'b0010, 9'h0));
    vecs.push_back(idle(0, 16'h0010, 8'h00, 4'b0010, 9'h0));
    vecs.push_back(idle(0, 16'h00FF, 8'h00, 4'b0010, 9'h0));
    vecs.push_back(idle(0, 16'h00FF, 8'h00, 4'b0010, 9'h0));
    vecs.push_back(idle(0, 16'h00FF, 8'h00, 4'b0110, 9'h1C3));
    // Second pair: CPU read 0x0020 wins, then SPI write 0x0030<-77.
    vecs.push_back(mk(0, 2'b10, 16'h0020, 8'h0, 2'b11, 16'h0030, 8'h77, 0, 0, 16'h00FF, 8'h0, 4'b0000, 9'h0));
    vecs.push_back(idle(0, 16'h00FF, 8'h00, 4'b0000, 9'h0));
    vecs.push_back(idle(0, 16'h0020, 8'h00, 4'b0000, 9'h0));
    vecs.push_back(idle(0, 16'h0020, 8'h00, 4'b0000, 9'h0));
    vecs.push_back(idle(0, 16'h0020, 8'h00, 4'b1010, 9'h15A));
    vecs.push_back(idle(1, 16'h0030, 8'h77, 4'b0010, 9'h0));
    vecs.push_back(idle(0, 16'h0030, 8'h77, 4'b0010, 9'h0));
    vecs.push_back(idle(0, 16'h0030, 8'h77, 4'b0110, 9'h0));
    vecs.push_back(idle(0, 16'h0030, 8'h77, 4'b0010, 9'h0));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      reset_n   = ~vecs[i].rst;
      cpu_req   = vecs[i].c[1];  cpu_we = vecs[i].c[0];
      cpu_addr  = vecs[i].ca;    cpu_wdata = vecs[i].cd;
      spi_req   = vecs[i].s[1];  spi_we = vecs[i].s[0];
      spi_addr  = vecs[i].sa;    spi_wdata = vecs[i].sd;
      spi_only  = vecs[i].so;
      #1;
      chk($sformatf("r%0d.ram_we", i), 32'(ram_we), 32'(vecs[i].ewe));
      chk($sformatf("r%0d.ram_addr", i), 32'(ram_addr), 32'(vecs[i].ea));
      chk($sformatf("r%0d.ram_din", i), 32'(ram_din), 32'(vecs[i].ed));
      chk($sformatf("r%0d.cpu_ack", i), 32'(cpu_ack), 32'(vecs[i].fl[3]));
      chk($sformatf("r%0d.spi_ack", i), 32'(spi_ack), 32'(vecs[i].fl[2]));
      chk($sformatf("r%0d.cpu_wait_n", i), 32'(cpu_wait_n), 32'(vecs[i].fl[1]));
      chk($sformatf("r%0d.spi_overrun", i), 32'(spi_overrun), 32'(vecs[i].fl[0]));
      if (vecs[i].erd[8] && vecs[i].fl[3])
        chk($sformatf("r%0d.cpu_rdata", i), 32'(cpu_rdata), 32'(vecs[i].erd[7:0]));
      if (vecs[i].erd[8] && vecs[i].fl[2])
        chk($sformatf("r%0d.spi_rdata", i), 32'(spi_rdata), 32'(vecs[i].erd[7:0]));
    end

    // spi_only holds a pending CPU read of 0x0040 while three SPI writes go through.
    @(negedge clk);
    spi_only = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0040; cpu_wdata = 8'h00;
    @(negedge clk);
    cpu_req = 1'b0;
    bad = 0; cack = 0; acks = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      spi_req = 1'b1; spi_we = 1'b1; spi_addr = 16'h0200 + 16'(k); spi_wdata = 8'hB0 + 8'(k);
      #1;
      if (cpu_wait_n !== 1'b0) bad++;
      got = 1'b0;
      for (int c = 0; c < 8 && !got; c++) begin
        @(negedge clk);
        spi_req = 1'b0;
        #1;
        if (cpu_wait_n !== 1'b0) bad++;
        if (cpu_ack) cack++;
        if (spi_ack) begin got = 1'b1; acks++; end
      end
    end
    spi_only = 1'b0;
    chk("spi_only.spi_acks", 32'(acks), 32'd3);
    chk("spi_only.wait_n_high_cycles", 32'(bad), 32'd0);
    chk("spi_only.cpu_acks", 32'(cack), 32'd0);
    @(negedge clk); #1;
    chk("release.ram_addr", 32'(ram_addr), 32'h0040);
    chk("release.cpu_ack_t1", 32'(cpu_ack), 32'd0);
    chk("release.wait_n_t1", 32'(cpu_wait_n), 32'd0);
    @(negedge clk); #1;
    chk("release.cpu_ack_t2", 32'(cpu_ack), 32'd0);
    @(negedge clk); #1;
    chk("release.cpu_ack_t3", 32'(cpu_ack), 32'd1);
    chk("release.cpu_rdata", 32'(cpu_rdata), 32'h7C);
    chk("release.wait_n_t3", 32'(cpu_wait_n), 32'd1);
    chk("spi_only.mem202", 32'(mem[16'h0202]), 32'hB2);

    // Back-to-back SPI pulses: second is dropped and flagged.
    @(negedge clk);
    spi_req = 1'b1; spi_we = 1'b1; spi_addr = 16'h0100; spi_wdata = 8'h11;
    #1;
    chk("ovr.before", 32'(spi_overrun), 32'd0);
    @(negedge clk);
    spi_addr = 16'h0101; spi_wdata = 8'h22;
    #1;
    chk("ovr.first_cycle", 32'(spi_overrun), 32'd0);
    @(negedge clk);
    spi_req = 1'b0;
    #1;
    chk("ovr.set", 32'(spi_overrun), 32'd1);
    wes = ram_we ? 1 : 0;
    chk("ovr.ram_addr", 32'(ram_addr), 32'h0100);
    acks = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk); #1;
      if (ram_we) wes++;
      if (spi_ack) acks++;
    end
    chk("ovr.spi_acks", 32'(acks), 32'd1);
    chk("ovr.ram_writes", 32'(wes), 32'd1);
    chk("ovr.sticky", 32'(spi_overrun), 32'd1);
    chk("ovr.mem100", 32'(mem[16'h0100]), 32'h11);
    chk("ovr.mem101", 32'(mem[16'h0101]), 32'h3C);

    // Reset asserted mid-ACCESS of an SPI write to 0x0300.
    @(negedge clk);
    spi_req = 1'b1; spi_we = 1'b1; spi_addr = 16'h0300; spi_wdata = 8'hEE;
    @(negedge clk);
    spi_req = 1'b0;
    @(negedge clk); #1;
    chk("rst.pre_ram_we", 32'(ram_we), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("rst.ram_we_now", 32'(ram_we), 32'd0);
    chk("rst.overrun_now", 32'(spi_overrun), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    hits = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); #1;
      if (spi_ack || ram_we) hits++;
    end
    chk("rst.no_ack_no_write", 32'(hits), 32'd0);
    chk("rst.cpu_rdata", 32'(cpu_rdata), 32'd0);
    chk("rst.spi_rdata", 32'(spi_rdata), 32'd0);
    chk("rst.ram_addr", 32'(ram_addr), 32'd0);
    chk("rst.ram_din", 32'(ram_din), 32'd0);
    chk("rst.acks", 32'({cpu_ack, spi_ack}), 32'd0);
    chk("rst.overrun", 32'(spi_overrun), 32'd0);
    chk("rst.wait_n", 32'(cpu_wait_n), 32'd1);
    chk("rst.mem300", 32'(mem[16'h0300]), 32'h3F);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single read/write port of the 64 KB boot/work dual-port RAM between the Z80 CPU and the ESP32 SPI slave loader.
- Without it, SPI loading muxes the port and stalls the CPU for the whole load. This block arbitrates per access, so SPI peeks and pokes can interleave with a running CPU.
- Stalls the CPU through its wait input only while a CPU access is outstanding.
- Sits between the CPU/SPI-slave request logic and RAM port A, in the CPU clock domain.

Parameters:
ADDR_BITS, 16, RAM address width
DATA_BITS, 8, RAM data width

Ports:
clk  in  1  CPU/system clock (25 MHz); all logic on rising edge
reset_n  in  1  asynchronous, active-low reset
cpu_req  in  1  one-cycle pulse: CPU memory access request (RAM chip-select decoded)
cpu_we  in  1  1=write, 0=read; sampled with cpu_req
cpu_addr  in  ADDR_BITS  sampled with cpu_req
cpu_wdata  in  DATA_BITS  sampled with cpu_req
cpu_rdata  out  DATA_BITS  read data, valid with cpu_ack
cpu_ack  out  1  one-cycle completion pulse
cpu_wait_n  out  1  to CPU wait_n; low while a CPU access is outstanding
spi_req  in  1  one-cycle pulse from SPI slave (wr or rd strobe, address space 0x00)
spi_we  in  1  1=write
spi_addr  in  ADDR_BITS  address
spi_wdata  in  DATA_BITS  write data
spi_rdata  out  DATA_BITS  read data, valid with spi_ack
spi_ack  out  1  one-cycle completion pulse
spi_only  in  1  level, from the CPU control register loader bit; blocks CPU grants
spi_overrun  out  1  sticky: an SPI request was dropped
ram_we  out  1  RAM port A write enable
ram_addr  out  ADDR_BITS  RAM port A address
ram_din  out  DATA_BITS  RAM port A write data
ram_dout  in  DATA_BITS  RAM port A read data, 1-cycle synchronous latency

Behaviour:
- Reset (async, immediate): state IDLE.
  - All pending flags, latches, cpu_rdata, spi_rdata, ram_addr and ram_din are 0.
  - ram_we=0, cpu_ack=0, spi_ack=0, spi_overrun=0.
  - last_grant=CPU.
  - cpu_wait_n=1 unless cpu_req is high.
- Request latch, one per requester:
  - A req pulse sets pending and captures we/addr/wdata.
  - A req while pending is ignored. For SPI this also sets spi_overrun; for CPU there is no flag.
  - A req on the same edge that pending clears wins: pending stays set with the new payload.
- FSM states: IDLE, ACCESS, DONE.
  - IDLE: choose the winner from pending requests. CPU is eligible only if spi_only=0.
    - Both eligible: grant the requester that is not last_grant (round-robin). The first contention after reset goes to SPI.
    - Winner found: set grant and last_grant, go to ACCESS. No eligible request: stay in IDLE.
  - ACCESS, one cycle:
    - ram_addr = granted addr.
    - ram_din = granted wdata.
    - ram_we = granted we.
    - Go to DONE.
  - DONE, one cycle:
    - ram_we=0; ram_addr and ram_din are held.
    - The granted rdata register loads ram_dout (loaded on writes too; that value is don't-care).
    - The granted ack is registered high for the next cycle.
    - The granted pending flag clears.
    - Go to IDLE.
- Latency:
  - req at edge 0 → ACCESS cycle 2 → DONE cycle 3 → ack high in cycle 4.
  - Back-to-back contention adds 3 cycles per access.
  - Each requester has at most one access outstanding.
- ram_we is high only during ACCESS; outside ACCESS, ram_addr and ram_din hold their last values.
- cpu_wait_n = ~(cpu_req | cpu_pending), combinational. It is high in the cycle cpu_ack is high.
- spi_only=1:
  - A CPU access already in ACCESS/DONE completes normally.
  - A pending CPU request stays pending and cpu_wait_n stays low.
  - SPI is served back-to-back.
  - When spi_only falls, the pending CPU access is granted at the next IDLE.
- Address and data pass through unmodified; there is no width conversion.

Decomposition:
- Package mem_arb_pkg:
  - state enum (IDLE, ACCESS, DONE).
  - grant enum (GNT_CPU, GNT_SPI).
  - ADDR_BITS/DATA_BITS default constants.
- Sub-module mem_arb_req_latch: pending flag, payload capture, overrun detect. Instantiated twice (CPU, SPI).
- Top holds the FSM, round-robin flag and output registers.

Test Plan:
- Reset, then SPI write 0x1234←0xA5 (req edge 0) → ram_we=1 with ram_addr=0x1234 and ram_din=0xA5 only in cycle 2; spi_ack in cycle 4; cpu_wait_n=1 throughout.
- CPU read of 0x1234 after the SPI write → cpu_wait_n low from the req cycle through cycle 3; cpu_ack and cpu_rdata=0xA5 in cycle 4.
- Simultaneous cpu_req (read 0x0010) and spi_req (write 0x0020←0x5A) after reset → SPI ACCESS cycle 2, spi_ack cycle 4; CPU ACCESS cycle 5, cpu_ack cycle 7. A second simultaneous pair → CPU granted first.
- spi_only=1 with a CPU read pending, then three SPI writes → all three SPI acks, cpu_wait_n stays 0. Drop spi_only → CPU ACCESS at the next IDLE, cpu_ack 3 cycles later.
- Two spi_req pulses 1 cycle apart (0x0100←0x11, then 0x0101←0x22) → spi_overrun=1 and stays 1; the RAM sees only the 0x0100 write; one spi_ack.
- reset_n low during ACCESS of an SPI write → ram_we=0 immediately; no spi_ack; after release all outputs are at reset values and spi_overrun=0.
